rob_tag_allocator: RTL
======================

# rob_tag_allocator

- Allocates reorder-buffer tags to the rename/decode stage and reclaims them at commit.
- Each cycle it offers WIDTH consecutive tags to the decoder lanes, advances its allocation pointer by the number of lanes actually consumed, and frees tags as the commit stage retires them in order.
- On a squash it rewinds the allocation pointer to the first squashed tag, then holds allocation off for one recovery cycle.

## Interface
- WIDTH, 4, decoder lanes served per cycle
- TAG_W, 5, tag width; ring holds N = 2**TAG_W entries
- RETIRE_W, 4, maximum tags retired per cycle
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- rob_tags  out  WIDTH*TAG_W  tag offered to lane k at [k*TAG_W +: TAG_W]; value is alloc_ptr+k mod N
- tags_valid  out  1  offered tags may be consumed
- alloc_take  in  WIDTH  lanes consuming their tag this cycle
- retire_count  in  clog2(RETIRE_W+1)  oldest tags freed this cycle
- flush_valid  in  1  squash request
- flush_tag  in  TAG_W  oldest squashed tag
- head_tag  out  TAG_W  retire_ptr, the oldest live tag
- occupancy  out  TAG_W+1  live entries, 0..N
- empty  out  1  occupancy==0
- full  out  1  occupancy==N
- alloc_err  out  1  sticky protocol-violation flag
- stall_cycles  out  32  statistics, see Configuration
- alloc_total  out  32  statistics, see Configuration

## Operation
- State registers:
  - alloc_ptr and retire_ptr, TAG_W bits each, wrapping mod N.
  - occ, TAG_W+1 bits.
  - FSM with states RUN and RECOVER.
- tags_valid = (state==RUN) && (N-occ >= WIDTH). Allocation is all-or-nothing on space; a partial offer is never made.
- Allocation, when tags_valid is high and flush_valid is low:
  - alloc_take must be a prefix mask (0, 1, 3, 7, 15 for WIDTH=4).
  - nalloc = popcount(alloc_take).
  - alloc_ptr += nalloc.
- Allocation violations: alloc_take nonzero while tags_valid is low, or a non-prefix mask.
  - The allocation is ignored; pointers do not move.
  - alloc_err is set.
- Retire:
  - nret = min(retire_count, occ).
  - retire_ptr += nret.
  - retire_count > occ sets alloc_err.
  - retire_count > RETIRE_W also sets alloc_err, and the value is clamped to RETIRE_W.
- Normal update: occ_next = occ + nalloc - nret. No overflow is possible because allocation requires free >= WIDTH.
- Flush (flush_valid high):
  - Allocation is suppressed that cycle. Any alloc_take is ignored without setting alloc_err.
  - Retire is still applied.
  - alloc_ptr_next = flush_tag.
  - occ_next = (flush_tag - retire_ptr_next) mod N. flush_tag == retire_ptr_next gives occ_next = 0 (everything squashed).
  - The flush must not squash retiring entries: if nret > (flush_tag - retire_ptr) mod N, alloc_err is set and occ_next is computed as stated.
- FSM transitions:
  - RUN stays in RUN without flush_valid.
  - RUN goes to RECOVER on flush_valid.
  - RECOVER returns to RUN after one cycle.
  - A flush while in RECOVER restarts RECOVER for one more cycle.
- alloc_err is cleared only by reset.

## Timing
- All state updates on the posedge of clk. All outputs are combinational from registers; there is no input-to-output combinational path.
- Handshake: tags are consumed in the same cycle alloc_take is sampled. The next rob_tags reflects the advanced pointer one cycle later.
- Flush latency:
  - Flush asserted in cycle t: tags_valid is low in cycle t+1 (RECOVER).
  - In cycle t+2, tags_valid is high and rob_tags start at flush_tag, provided space is available.
- Reset (asynchronous, any time including mid-flush or mid-allocation):
  - alloc_ptr = retire_ptr = 0, occ = 0, state = RUN, alloc_err = 0, statistics = 0.
  - Output values under reset: tags_valid = 1, rob_tags = {3,2,1,0}, head_tag = 0, occupancy = 0, empty = 1, full = 0.
- Wrap-around: pointers wrap mod N silently. occ, not pointer equality, distinguishes full from empty.

## Configuration
- ROB_ALLOC_STATS_EN defined:
  - stall_cycles counts cycles with tags_valid low, saturating at 2^32-1.
  - alloc_total accumulates nalloc, wrapping.
  - Both clear on reset and are unaffected by flush.
- ROB_ALLOC_STATS_EN undefined: both outputs are constant 0, and no counter registers are inferred.

## Test plan
- Reset release -> tags_valid=1, rob_tags={3,2,1,0}, empty=1, occupancy=0, alloc_err=0.
- alloc_take=4'b1111 for 8 consecutive cycles:
  - After cycle 7: occupancy=28, tags_valid=1, rob_tags={31,30,29,28}.
  - After cycle 8: occupancy=32, full=1, tags_valid=0.
- From full, retire_count=4 -> occupancy=28, head_tag=4, tags_valid=1, rob_tags={3,2,1,0} (wrap).
- From alloc_ptr=12, retire_ptr=0:
  - Apply flush_valid with flush_tag=5 and alloc_take=4'b1111 together -> next cycle alloc_ptr=5, occupancy=5, tags_valid=0, alloc_err=0.
  - The following cycle: tags_valid=1, rob_tags={8,7,6,5}.
- Protocol violations:
  - alloc_take=4'b0101 -> pointers unchanged, alloc_err=1 and stays set.
  - Separately, retire_count=3 with occupancy=1 -> occupancy=0, head_tag advances by 1, alloc_err=1.
- With ROB_ALLOC_STATS_EN: 8 full allocations then 3 stalled cycles -> alloc_total=32, stall_cycles=3. Without the macro, both read 0.

Source files
------------

// File: rtl/rob_tag_allocator.sv
// Reorder-buffer tag allocator: offers WIDTH consecutive ring tags per cycle,
// reclaims them in order at commit, rewinds on squash. Stats gated by ROB_ALLOC_STATS_EN.
module rob_tag_allocator #(
    parameter int WIDTH    = 4,
    parameter int TAG_W    = 5,
    parameter int RETIRE_W = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    output logic [WIDTH*TAG_W-1:0]           rob_tags,
    output logic                             tags_valid,
    input  logic [WIDTH-1:0]                 alloc_take,
    input  logic [$clog2(RETIRE_W+1)-1:0]    retire_count,
    input  logic                             flush_valid,
    input  logic [TAG_W-1:0]                 flush_tag,
    output logic [TAG_W-1:0]                 head_tag,
    output logic [TAG_W:0]                   occupancy,
    output logic                             empty,
    output logic                             full,
    output logic                             alloc_err,
    output logic [31:0]                      stall_cycles,
    output logic [31:0]                      alloc_total
);

    localparam int N     = 1 << TAG_W;
    localparam int OCC_W = TAG_W + 1;
    localparam int RC_W  = $clog2(RETIRE_W + 1);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        RUN,
        RECOVER
    } state_e;

    state_e               state_q, state_d;
    logic [TAG_W-1:0]     alloc_ptr_q, alloc_ptr_d;
    logic [TAG_W-1:0]     retire_ptr_q, retire_ptr_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic                 alloc_err_q, alloc_err_d;

    logic [OCC_W-1:0]     free_slots;
    logic [CNT_W-1:0]     take_count;
    logic                 take_prefix;
    logic                 alloc_ok;
    logic                 alloc_viol;
    logic [CNT_W-1:0]     nalloc;
    logic                 rc_over;
    logic [RC_W-1:0]      rc_clamped;
    logic                 retire_err;
    logic [OCC_W-1:0]     nret;
    logic [TAG_W-1:0]     retire_ptr_nxt;
    logic [TAG_W-1:0]     squash_span;
    logic [TAG_W-1:0]     flush_occ;
    logic                 flush_err;

    // Offer side: purely a function of registered state.
    always_comb begin
        free_slots = OCC_W'(N) - occ_q;
        tags_valid = (state_q == RUN) && (free_slots >= OCC_W'(WIDTH));
        for (int k = 0; k < WIDTH; k++) begin
            rob_tags[k*TAG_W +: TAG_W] = alloc_ptr_q + TAG_W'(k);
        end
    end

    // Allocation decode. x & (x+1) == 0 holds exactly for low-order prefix masks.
    always_comb begin
        take_count = '0;
        for (int k = 0; k < WIDTH; k++) begin
            take_count = take_count + CNT_W'(alloc_take[k]);
        end
        take_prefix = ((alloc_take & (alloc_take + WIDTH'(1))) == '0);
        alloc_ok    = !flush_valid && tags_valid && take_prefix;
        alloc_viol  = !flush_valid && (|alloc_take) && (!tags_valid || !take_prefix);
        nalloc      = alloc_ok ? take_count : '0;
    end

    // Retire decode; squash_span/flush_occ stay TAG_W wide so subtraction wraps mod N.
    always_comb begin
        rc_over        = (retire_count > RC_W'(RETIRE_W));
        rc_clamped     = rc_over ? RC_W'(RETIRE_W) : retire_count;
        retire_err     = rc_over || (32'(retire_count) > 32'(occ_q));
        nret           = (OCC_W'(rc_clamped) > occ_q) ? occ_q : OCC_W'(rc_clamped);
        retire_ptr_nxt = retire_ptr_q + TAG_W'(nret);
        squash_span    = flush_tag - retire_ptr_q;
        flush_occ      = flush_tag - retire_ptr_nxt;
        flush_err      = flush_valid && (nret > {1'b0, squash_span});
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        alloc_ptr_d  = alloc_ptr_q;
        retire_ptr_d = retire_ptr_nxt;
        occ_d        = occ_q;
        state_d      = state_q;
        alloc_err_d  = alloc_err_q | alloc_viol | retire_err | flush_err;

        if (flush_valid) begin
            alloc_ptr_d = flush_tag;
            occ_d       = {1'b0, flush_occ};
        end else begin
            alloc_ptr_d = alloc_ptr_q + TAG_W'(nalloc);
            occ_d       = occ_q + OCC_W'(nalloc) - nret;
        end

        case (state_q)
            RUN:     state_d = flush_valid ? RECOVER : RUN;
            RECOVER: state_d = flush_valid ? RECOVER : RUN;
            default: state_d = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            alloc_ptr_q  <= '0;
            retire_ptr_q <= '0;
            occ_q        <= '0;
            alloc_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            alloc_ptr_q  <= alloc_ptr_d;
            retire_ptr_q <= retire_ptr_d;
            occ_q        <= occ_d;
            alloc_err_q  <= alloc_err_d;
        end
    end

    assign head_tag  = retire_ptr_q;
    assign occupancy = occ_q;
    assign empty     = (occ_q == '0);
    assign full      = (occ_q == OCC_W'(N));
    assign alloc_err = alloc_err_q;

`ifdef ROB_ALLOC_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] alloc_total_q, alloc_total_d;

    // Stall count saturates; allocation total wraps.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!tags_valid && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        alloc_total_d = alloc_total_q + 32'(nalloc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            alloc_total_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            alloc_total_q  <= alloc_total_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign alloc_total  = alloc_total_q;
`else
    assign stall_cycles = 32'd0;
    assign alloc_total  = 32'd0;
`endif

endmodule
